// File: rtl/stack_ctrl.sv
// stack_ctrl: initiator-side sequencer for the 16-entry lifo_stack.
// Turns held push/pop(/peek) requests into ordered stack strobes, guards
// full/empty with sticky ovf/unf flags, and tracks occupancy in level_o.
// Optional feature macro: STACK_CTRL_PEEK_EN (adds the non-destructive peek).
module stack_ctrl #(
  parameter int DW = 4,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_req,
  input  logic          push_sel,
  input  logic          pop_req,
  input  logic          peek_req,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] pc_in,
  input  logic          stack_full_i,
  input  logic          stack_empty_i,
  input  logic [DW-1:0] stack_data_i,
  output logic          stack_push_o,
  output logic          stack_pop_o,
  output logic          stack_we_o,
  output logic          stack_re_o,
  output logic          stack_mux_sel_o,
  output logic [DW-1:0] stack_data_1_o,
  output logic [DW-1:0] stack_data_2_o,
  output logic          stack_rst_o,
  output logic          busy_o,
  output logic          ack_o,
  output logic [DW-1:0] ret_data_o,
  output logic          ovf_o,
  output logic          unf_o,
  output logic [AW-1:0] level_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUSH    = 3'd1;
  localparam logic [2:0] S_POP_DEC = 3'd2;
  localparam logic [2:0] S_POP_RD  = 3'd3;
`ifdef STACK_CTRL_PEEK_EN
  localparam logic [2:0] S_PK_DEC  = 3'd4;
  localparam logic [2:0] S_PK_RD   = 3'd5;
  localparam logic [2:0] S_PK_INC  = 3'd6;
`endif
  localparam logic [2:0] S_DONE    = 3'd7;

  localparam logic [AW-1:0] LEVEL_MAX = AW'(16);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       can_accept;
  logic       acc_pop;
  logic       acc_peek;
  logic       acc_push;
  logic       acc_any;
  logic       lvl_inc;
  logic       lvl_dec;
  logic       rd_state;

  // The stack is still in reset while stack_rst_o is high, so hold off requests.
  assign can_accept = (state == S_IDLE) && !stack_rst_o;

`ifdef STACK_CTRL_PEEK_EN
  assign acc_peek = can_accept && !pop_req && peek_req;
  assign acc_push = can_accept && !pop_req && !peek_req && push_req;
`else
  logic unused_peek;
  assign unused_peek = peek_req;
  assign acc_peek    = 1'b0;
  assign acc_push    = can_accept && !pop_req && push_req;
`endif
  assign acc_pop = can_accept && pop_req;
  assign acc_any = acc_pop || acc_peek || acc_push;

  // Strobes and status are pure decodes of the registered state.
  assign stack_we_o   = (state == S_PUSH);
`ifdef STACK_CTRL_PEEK_EN
  assign stack_push_o = (state == S_PUSH) || (state == S_PK_INC);
  assign stack_pop_o  = (state == S_POP_DEC) || (state == S_PK_DEC);
  assign rd_state     = (state == S_POP_RD) || (state == S_PK_RD);
`else
  assign stack_push_o = (state == S_PUSH);
  assign stack_pop_o  = (state == S_POP_DEC);
  assign rd_state     = (state == S_POP_RD);
`endif
  assign stack_re_o = rd_state;
  assign busy_o     = (state != S_IDLE);
  assign ack_o      = (state == S_DONE);
  assign lvl_inc    = stack_push_o;
  assign lvl_dec    = stack_pop_o;

  // Next-state decode; priority pop > peek > push, full/empty short-cuts to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (can_accept) begin
          if (pop_req)
            state_nxt = stack_empty_i ? S_DONE : S_POP_DEC;
`ifdef STACK_CTRL_PEEK_EN
          else if (peek_req)
            state_nxt = stack_empty_i ? S_DONE : S_PK_DEC;
`endif
          else if (push_req)
            state_nxt = stack_full_i ? S_DONE : S_PUSH;
        end
      end
      S_PUSH:    state_nxt = S_DONE;
      S_POP_DEC: state_nxt = S_POP_RD;
      S_POP_RD:  state_nxt = S_DONE;
`ifdef STACK_CTRL_PEEK_EN
      S_PK_DEC:  state_nxt = S_PK_RD;
      S_PK_RD:   state_nxt = S_PK_INC;
      S_PK_INC:  state_nxt = S_DONE;
`endif
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Stack reset: asserted with rst_n, released after the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stack_rst_o <= 1'b1;
    else        stack_rst_o <= 1'b0;
  end

  // Capture payloads and push source when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_data_1_o  <= '0;
      stack_data_2_o  <= '0;
      stack_mux_sel_o <= 1'b0;
    end else if (acc_any) begin
      stack_data_1_o  <= data_in;
      stack_data_2_o  <= pc_in;
      stack_mux_sel_o <= push_sel;
    end
  end

  // Return register loads the stack read data in the read state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ret_data_o <= '0;
    else if (rd_state) ret_data_o <= stack_data_i;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      if (acc_push && stack_full_i)                ovf_o <= 1'b1;
      if ((acc_pop || acc_peek) && stack_empty_i)  unf_o <= 1'b1;
    end
  end

  // Occupancy counter follows the pointer moves, saturating at 0 and 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      level_o <= '0;
    else if (lvl_inc && (level_o != LEVEL_MAX))
      level_o <= level_o + 1'b1;
    else if (lvl_dec && (level_o != '0))
      level_o <= level_o - 1'b1;
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: scoreboard bench for stack_ctrl with a behavioural 16-entry LIFO.
// Define STACK_CTRL_PEEK_EN to also exercise the peek sequence.
module tb_stack_ctrl;

  localparam int DW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push_req, push_sel, pop_req, peek_req;
  logic [DW-1:0] data_in, pc_in;
  logic          stack_full_i, stack_empty_i;
  logic [DW-1:0] stack_data_i;
  logic          stack_push_o, stack_pop_o, stack_we_o, stack_re_o, stack_mux_sel_o;
  logic [DW-1:0] stack_data_1_o, stack_data_2_o;
  logic          stack_rst_o, busy_o, ack_o, ovf_o, unf_o;
  logic [DW-1:0] ret_data_o;
  logic [AW-1:0] level_o;

  always #5 clk = ~clk;

  stack_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_req(push_req), .push_sel(push_sel), .pop_req(pop_req), .peek_req(peek_req),
    .data_in(data_in), .pc_in(pc_in),
    .stack_full_i(stack_full_i), .stack_empty_i(stack_empty_i), .stack_data_i(stack_data_i),
    .stack_push_o(stack_push_o), .stack_pop_o(stack_pop_o), .stack_we_o(stack_we_o),
    .stack_re_o(stack_re_o), .stack_mux_sel_o(stack_mux_sel_o),
    .stack_data_1_o(stack_data_1_o), .stack_data_2_o(stack_data_2_o),
    .stack_rst_o(stack_rst_o), .busy_o(busy_o), .ack_o(ack_o),
    .ret_data_o(ret_data_o), .ovf_o(ovf_o), .unf_o(unf_o), .level_o(level_o)
  );

  // Behavioural lifo_stack: write lands at the pointer then it increments;
  // pop decrements; read data is the entry at the pointer while re is high.
  logic [DW-1:0] mem [16];
  logic [4:0]    sp = '0;

  always @(posedge clk) begin
    if (stack_rst_o) sp <= '0;
    else if (stack_push_o) begin
      if (stack_we_o) mem[sp[3:0]] <= stack_mux_sel_o ? stack_data_1_o : stack_data_2_o;
      if (sp != 5'd16) sp <= sp + 5'd1;
    end else if (stack_pop_o && sp != 5'd0) sp <= sp - 5'd1;
  end

  assign stack_full_i  = (sp == 5'd16);
  assign stack_empty_i = (sp == 5'd0);
  assign stack_data_i  = stack_re_o ? mem[sp[3:0]] : '0;

  typedef struct {
    int ret; int level; int ovf; int unf; int lat; int we; int po;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   conflicts = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t mk(int ret, int level, int ovf, int unf, int lat, int we, int po);
    exp_t e;
    e.ret = ret; e.level = level; e.ovf = ovf; e.unf = unf;
    e.lat = lat; e.we = we; e.po = po;
    return e;
  endfunction

  // Monitor: measures each operation and pops an expectation on every ack.
  int   lat_cnt = 0, we_cnt = 0, po_cnt = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) prev_busy = 1'b0;
    else begin
      if (busy_o && !prev_busy) begin lat_cnt = 1; we_cnt = 0; po_cnt = 0; end
      else if (busy_o) lat_cnt++;
      if (stack_we_o) we_cnt++;
      if (stack_pop_o) po_cnt++;
      if (stack_push_o && stack_pop_o) conflicts++;
      if (ack_o) begin
        if (exp_q.size() == 0) checkOutput("unexpected_ack", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("ret_data", int'(ret_data_o), e.ret);
          checkOutput("level", int'(level_o), e.level);
          checkOutput("ovf", int'(ovf_o), e.ovf);
          checkOutput("unf", int'(unf_o), e.unf);
          checkOutput("latency", lat_cnt, e.lat);
          checkOutput("we_count", we_cnt, e.we);
          checkOutput("pop_strobe_count", po_cnt, e.po);
        end
      end
      prev_busy = busy_o;
    end
  end

  task automatic waitAck();
    int n = 0;
    do begin @(negedge clk); n++; end while (!ack_o && n < 20);
    checkOutput("ack_seen", int'(ack_o), 1);
  endtask

  // Issue one operation, queue its expectation, hold until ack, then idle a cycle.
  task automatic applyStimulus(input bit do_push, input bit do_pop, input bit do_peek,
                               input logic sel, input logic [DW-1:0] din,
                               input logic [DW-1:0] pc, input exp_t e);
    exp_q.push_back(e);
    push_sel = sel; data_in = din; pc_in = pc;
    push_req = do_push; pop_req = do_pop; peek_req = do_peek;
    waitAck();
    push_req = 0; pop_req = 0; peek_req = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 0; push_req = 0; pop_req = 0; peek_req = 0;
    push_sel = 0; data_in = '0; pc_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_stack_rst", int'(stack_rst_o), 1);
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_ack", int'(ack_o), 0);
    checkOutput("rst_level", int'(level_o), 0);
    checkOutput("rst_ret", int'(ret_data_o), 0);
    checkOutput("rst_flags", int'({ovf_o, unf_o}), 0);
    checkOutput("rst_strobes", int'({stack_push_o, stack_pop_o, stack_we_o, stack_re_o}), 0);
    checkOutput("rst_latched", int'({stack_data_1_o, stack_data_2_o, stack_mux_sel_o}), 0);

    // Release reset with a push already pending: it must wait out stack_rst_o.
    exp_q.push_back(mk(0, 1, 0, 0, 2, 1, 0));
    push_sel = 1; data_in = 4'hA; pc_in = 4'h0; push_req = 1;
    rst_n = 1;
    #1 checkOutput("stack_rst_after_release", int'(stack_rst_o), 1);
    @(negedge clk);
    checkOutput("stack_rst_dropped", int'(stack_rst_o), 0);
    checkOutput("no_accept_in_stack_rst", int'(busy_o), 0);
    checkOutput("stack_empty_seen", int'(stack_empty_i), 1);
    waitAck();
    push_req = 0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 1'b0, 4'hC, 4'h3, mk(3'h0, 2, 0, 0, 2, 1, 0));
    applyStimulus(0, 1, 0, 1'b0, 4'h0, 4'h0, mk(4'h3, 1, 0, 0, 3, 0, 1));
    applyStimulus(0, 1, 0, 1'b0, 4'h0, 4'h0, mk(4'hA, 0, 0, 0, 3, 0, 1));
    // Pop on empty: underflow, return register keeps 4'hA, no pop strobe.
    applyStimulus(0, 1, 0, 1'b0, 4'h0, 4'h0, mk(4'hA, 0, 0, 1, 1, 0, 0));

    for (int i = 0; i < 16; i++)
      applyStimulus(1, 0, 0, 1'b1, 4'(i), 4'h0, mk(4'hA, i + 1, 0, 1, 2, 1, 0));
    // 17th push hits full.
    applyStimulus(1, 0, 0, 1'b1, 4'h1, 4'h0, mk(4'hA, 16, 1, 1, 1, 0, 0));
    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1, 0, 1'b0, 4'h0, 4'h0, mk(15 - i, 15 - i, 1, 1, 3, 0, 1));

    applyStimulus(1, 0, 0, 1'b1, 4'h5, 4'h0, mk(0, 1, 1, 1, 2, 1, 0));
    // Push and pop together: pop wins, push follows in the next IDLE.
    exp_q.push_back(mk(5, 0, 1, 1, 3, 0, 1));
    exp_q.push_back(mk(5, 1, 1, 1, 2, 1, 0));
    push_sel = 1; data_in = 4'h9; pc_in = 4'h0;
    push_req = 1; pop_req = 1;
    waitAck();
    pop_req = 0;
    waitAck();
    push_req = 0;
    @(negedge clk);
    applyStimulus(0, 1, 0, 1'b0, 4'h0, 4'h0, mk(9, 0, 1, 1, 3, 0, 1));

`ifdef STACK_CTRL_PEEK_EN
    applyStimulus(1, 0, 0, 1'b1, 4'h7, 4'h0, mk(9, 1, 1, 1, 2, 1, 0));
    applyStimulus(0, 0, 1, 1'b0, 4'h0, 4'h0, mk(7, 1, 1, 1, 4, 0, 1));
    applyStimulus(0, 1, 0, 1'b0, 4'h0, 4'h0, mk(7, 0, 1, 1, 3, 0, 1));
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("push_pop_conflict", conflicts, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
